// File: rtl/moving_avg_pkg.sv
// Shared types and widths for the moving-average scheduler slice.
package moving_avg_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W       = $clog2(NUM_CH_DEF);
  // AVG_LAT and GAP are both capped at 7, so one counter width covers either.
  localparam int CNT_MAX    = 7;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;
endpackage

// File: rtl/mavg_rr_arbiter.sv
// Combinational round-robin pick of the first full channel at or after ptr.
// MAVG_SCHED_PRIO_EN: channel 0 overrides the rotation whenever it is full.
module mavg_rr_arbiter
  import moving_avg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = CH_W
) (
  input  logic [NUM_CH-1:0] full,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);
  logic found;
  int   c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    // ptr < NUM_CH always, so a single subtract wraps non-power-of-2 counts.
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (en && !found && full[c]) begin
        found   = 1'b1;
        gnt     = '0;
        gnt[c]  = 1'b1;
        gnt_idx = IDX_W'(c);
      end
    end
`ifdef MAVG_SCHED_PRIO_EN
    if (en && full[0]) begin
      gnt     = NUM_CH'(1);
      gnt_idx = '0;
    end
`endif
  end
endmodule

// File: rtl/moving_avg_scheduler.sv
// Shares one strobe-driven averager among NUM_CH single-entry sample buffers.
// Build option MAVG_SCHED_PRIO_EN gives channel 0 strict priority.
module moving_avg_scheduler
  import moving_avg_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int AVG_LAT = 1,
  parameter int GAP     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*DATA_W-1:0]  req_data,
  output logic [NUM_CH-1:0]         req_ready,
  output logic                      avg_strobe,
  output logic [DATA_W-1:0]         avg_data,
  output logic [$clog2(NUM_CH)-1:0] avg_ch,
  input  logic [DATA_W-1:0]         avg_result,
  output logic                      res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  input  logic                      res_ready
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(AVG_LAT);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP);

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][DATA_W-1:0] buf_q;
  logic [NUM_CH-1:0]             full_q, full_d, load, arb_gnt, gnt_oh_q;
  logic [CW-1:0]                 ptr_q, ptr_nxt, arb_idx, gnt_idx_q;
  logic                          take, lat_done, gap_done;

  assign lat_done = (cnt_q == LAT_C);
  assign gap_done = (cnt_q == GAP_C);
  assign load     = req_valid & req_ready;
  assign ptr_nxt  = (arb_idx == CW'(NUM_CH - 1)) ? '0 : arb_idx + CW'(1);

  mavg_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(CW)) u_arb (
    .full    (full_q),
    .ptr     (ptr_q),
    .en      (take),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE is passed through without a dead cycle when work is already
  // buffered, so back-to-back strobes sit 1+AVG_LAT+1+GAP cycles apart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE:  take = |full_q;
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT:  begin
        if (lat_done) state_d = ST_HOLD;
        else          cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_HOLD:  begin
        if (res_ready) begin
          if (GAP == 0) begin
            state_d = ST_IDLE;
            take    = |full_q;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_GAP:   begin
        if (gap_done) begin
          state_d = ST_IDLE;
          take    = |full_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (take) state_d = ST_ISSUE;
  end

  // A granted buffer is released at the end of its ISSUE cycle.
  always_comb begin
    full_d = full_q | load;
    if (state_q == ST_ISSUE) full_d = full_d & ~gnt_oh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      req_ready  <= '1;
      buf_q      <= '0;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      avg_strobe <= 1'b0;
      avg_data   <= '0;
      avg_ch     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ch     <= '0;
    end else begin
      full_q     <= full_d;
      req_ready  <= ~full_d;
      avg_strobe <= take;
      for (int i = 0; i < NUM_CH; i++)
        if (load[i]) buf_q[i] <= req_data[i*DATA_W +: DATA_W];
      if (take) begin
        gnt_idx_q <= arb_idx;
        gnt_oh_q  <= arb_gnt;
        avg_data  <= buf_q[arb_idx];
        avg_ch    <= arb_idx;
`ifdef MAVG_SCHED_PRIO_EN
        if (arb_idx != '0) ptr_q <= ptr_nxt;
`else
        ptr_q <= ptr_nxt;
`endif
      end
      if (state_q == ST_WAIT && lat_done) begin
        res_valid <= 1'b1;
        res_data  <= avg_result;
        res_ch    <= gnt_idx_q;
      end else if (state_q == ST_HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_moving_avg_scheduler.sv
// Scoreboard bench for moving_avg_scheduler with a data+1 averager model.
module tb_moving_avg_scheduler;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready;
  logic                     avg_strobe;
  logic [DATA_W-1:0]        avg_data;
  logic [1:0]               avg_ch;
  logic [DATA_W-1:0]        avg_result = '0;
  logic                     res_valid;
  logic [DATA_W-1:0]        res_data;
  logic [1:0]               res_ch;
  logic                     res_ready;

  always #5 clk = ~clk;

  moving_avg_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LAT(1), .GAP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .avg_strobe (avg_strobe),
    .avg_data   (avg_data),
    .avg_ch     (avg_ch),
    .avg_result (avg_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ch     (res_ch),
    .res_ready  (res_ready)
  );

  // Averager: result is data+1, valid one cycle after the strobe.
  always @(posedge clk) if (avg_strobe) avg_result <= avg_data + 8'd1;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t res_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_stb = -1;
  bit   spacing_on = 1'b0;
  bit   stall_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic expect_txn(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = d;
    gnt_q.push_back(e);
    e.data = d + 8'd1;
    res_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((gnt_q.size() != 0 || res_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", gnt_q.size() + res_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (avg_strobe) begin
        if (stall_on) chk("stall_strobe", 1, 0);
        if (gnt_q.size() == 0) chk("strobe_unexp", 1, 0);
        else begin
          mon_e = gnt_q.pop_front();
          chk("strobe_ch", 32'(avg_ch), 32'(mon_e.ch));
          chk("strobe_data", 32'(avg_data), 32'(mon_e.data));
        end
        if (spacing_on && last_stb >= 0) chk("strobe_space", cyc - last_stb, 4);
        last_stb = cyc;
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) chk("res_unexp", 1, 0);
        else begin
          mon_e = res_q.pop_front();
          chk("res_ch", 32'(res_ch), 32'(mon_e.ch));
          chk("res_data", 32'(res_data), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'hf);
    chk("rst_strobe", 32'(avg_strobe), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_avg_data", 32'(avg_data), 0);
    chk("rst_avg_ch", 32'(avg_ch), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_ch", 32'(res_ch), 0);

    // single sample on ch2: latency of strobe and result
    expect_txn(2, 8'h03);
    @(posedge clk); #1;
    req_data[2*DATA_W +: DATA_W] = 8'h03; req_valid = 4'b0100;
    @(posedge clk); #1 req_valid = '0;
    chk("ready_full", 32'(req_ready[2]), 0);
    @(negedge clk) chk("strobe_early", 32'(avg_strobe), 0);
    @(negedge clk) chk("strobe_lat", 32'(avg_strobe), 1);
    @(negedge clk);
    chk("res_early", 32'(res_valid), 0);
    chk("ready_free", 32'(req_ready[2]), 1);
    @(negedge clk) chk("res_lat", 32'(res_valid), 1);
    drain();

    // all four at once: order 0..3, strobes four cycles apart, ptr wraps
    do_reset();
    for (int i = 0; i < 4; i++) expect_txn(i, 8'(i + 1));
    spacing_on = 1'b1; last_stb = -1;
    req_data = {8'h04, 8'h03, 8'h02, 8'h01}; req_valid = 4'hf;
    @(posedge clk); #1 req_valid = '0;
    drain();
    spacing_on = 1'b0;
    expect_txn(0, 8'h0a); expect_txn(3, 8'h0d);
    req_data = {8'h0d, 8'h00, 8'h00, 8'h0a}; req_valid = 4'b1001;
    @(posedge clk); #1 req_valid = '0;
    drain();

    // consumer stall holding a ch1 result
    res_ready = 1'b0;
    expect_txn(1, 8'h11);
    req_data[1*DATA_W +: DATA_W] = 8'h11; req_valid = 4'b0010;
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall_reach", 32'(res_valid), 1);
    stall_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        expect_txn(3, 8'h33);
        req_data[3*DATA_W +: DATA_W] = 8'h33; req_valid = 4'b1000;
      end
      if (i == 3) req_valid = '0;
      @(negedge clk);
      chk("stall_valid", 32'(res_valid), 1);
      chk("stall_data", 32'(res_data), 32'h12);
      chk("stall_ch", 32'(res_ch), 1);
      @(posedge clk); #1;
    end
    chk("held_ready3", 32'(req_ready[3]), 0);
    stall_on = 1'b0; res_ready = 1'b1;
    @(negedge clk) chk("rel_hold", 32'(avg_strobe), 0);
    @(negedge clk) chk("rel_gap", 32'(avg_strobe), 0);
    @(negedge clk) chk("rel_issue", 32'(avg_strobe), 1);
    drain();

    // reset while waiting on ch0 with ch3 still buffered
    mon_e.ch = 2'd0; mon_e.data = 8'h21;
    gnt_q.push_back(mon_e);
    req_data = {8'h24, 8'h00, 8'h00, 8'h21}; req_valid = 4'b1001;
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!avg_strobe && n < 20);
    chk("wait_reach", 32'(avg_strobe), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'hf);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_strobe", 32'(avg_strobe), 0);
    chk("mid_rst_avg_data", 32'(avg_data), 0);
    chk("mid_rst_avg_ch", 32'(avg_ch), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_sb", gnt_q.size() + res_q.size(), 0);

    // ch0 re-requests while ch1 and ch2 wait
`ifdef MAVG_SCHED_PRIO_EN
    expect_txn(0, 8'h10); expect_txn(0, 8'h60); expect_txn(1, 8'h11); expect_txn(2, 8'h12);
`else
    expect_txn(0, 8'h10); expect_txn(1, 8'h11); expect_txn(2, 8'h12); expect_txn(0, 8'h60);
`endif
    req_data = {8'h00, 8'h12, 8'h11, 8'h10}; req_valid = 4'b0111;
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!avg_strobe && n < 20);
    @(posedge clk); #1;
    req_data[7:0] = 8'h60; req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
